pmod_keypad_scan: RTL and testbench
===================================

// Module: pmod_keypad_scan
// PURPOSE
//  Input-side PMOD reader: scans a 4x4 matrix keypad on one PMOD connector. Drives columns
//  active-low one at a time, samples pulled-up rows, debounces the full 16-key image and
//  reports single-key presses as a code plus a one-cycle strobe. Consumers are LED/UI logic
//  in the same top level. Ghost/multi-key images never produce a strobe.
// PARAMETERS
//  frequency        50_000_000  clk frequency in Hz
//  scan_us          250         dwell time per column in us; col_ticks = frequency/1_000_000*scan_us (>=4)
//  debounce_sweeps  20          consecutive identical full sweeps required to accept a new image (>=2)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  col_n      out  4  column drive, active-low, exactly one bit low at all times
//  row_n      in   4  row sense, active-low (external pull-ups), asynchronous to clk
//  key_code   out  4  code of last accepted key = row*4 + col
//  key_valid  out  1  one-cycle strobe when a new single key is accepted
//  key_held   out  1  high while the accepted single key remains the only key down
// BEHAVIOUR
//  Reset: col_n=4'b1110, key_code=0, key_valid=0, key_held=0, state=IDLE, all counters/images 0.
//  Sync: row_n passes through a 2-flop synchroniser before any use.
//  Scan: tick counter 0..col_ticks-1 per column; col index 0..3, wraps 3->0. Rows are sampled
//   on the last tick of a dwell (settling >= col_ticks-3 cycles after synchroniser). Bit
//   [row*4+col] of the sweep image = ~row_sync[row]. col_n advances on the cycle after the sample.
//  Sweep end = sample of col 3. Then: if image==prev_image, match_cnt++ (saturating at
//   debounce_sweeps-1), else match_cnt=0. prev_image<=image every sweep.
//   When match_cnt reaches debounce_sweeps-1 and image!=stable, stable<=image (one update).
//  FSM, evaluated the cycle after stable changes (popcount of stable = n):
//   IDLE    : n==1 -> PRESSED, key_code<=index, key_valid=1 for 1 cycle, key_held=1
//             n>=2 -> MULTI (no strobe)
//   PRESSED : n==0 -> IDLE, key_held=0; any other change -> MULTI, key_held=0, no strobe
//   MULTI   : n==0 -> IDLE; stays MULTI otherwise (a press only counts from IDLE)
//  key_code holds its value until the next accepted press; unchanged on release/MULTI.
//  Latency: key_valid rises 2 cycles after the end of the debounce_sweeps-th identical sweep.
//  Bounce at any point restarts match_cnt; no strobe ever emitted from a non-stable image.
//  rst_n low mid-dwell or mid-strobe: immediate return to reset values; the first sweep
//   after release starts at col 0, tick 0.
// STRUCTURE
//  Package pmod_pkg: PMOD_ROWS=4, PMOD_COLS=4, KEY_W=4, FSM state enum {IDLE,PRESSED,MULTI},
//   default frequency constant shared with other PMOD blocks.
//  Sub-module pmod_sync2 (parameterised-width 2-flop synchroniser, async active-low reset,
//   reset value all-ones for active-low inputs). Scan, debounce and FSM stay in this module.
// TESTING  (bench: frequency=1_000_000, scan_us=8 -> 8 cycles/col, 32/sweep; debounce_sweeps=3;
//  keypad model pulls row_n[r] low while col_n[c]==0 and key (r,c) is pressed)
//  1 Reset then idle 200 cycles -> col_n cycles 1110,1101,1011,0111 every 8 cycles; key_valid never 1.
//  2 Press key (2,1) clean -> exactly one key_valid with key_code=9, key_held=1, within 3 sweeps+2 cycles
//    of the first full sweep seeing it; release -> key_held=0 after 3 sweeps, key_code stays 9.
//  3 Press (0,3) bouncing every 20 cycles for 5 sweeps, then stable -> single strobe, code=3,
//    first strobe no earlier than 3 stable sweeps after bouncing stops.
//  4 Hold (1,0), then add (3,2) -> no second strobe, key_held=0; release both; press (3,3)
//    -> strobe code=15.
//  5 Press (0,0)+(1,1) together from idle -> no strobe, key_held=0; release (1,1) only -> still no
//    strobe (MULTI); release all, press (1,1) -> strobe code=5.
//  6 Assert rst_n low 2 cycles during a held key mid-dwell -> outputs to reset values at once;
//    key still held after release -> new strobe with same code after 3 stable sweeps.

Source files
------------

// File: rtl/pmod_pkg.sv
// Shared PMOD definitions: keypad geometry, key FSM states and key-image helpers.
// Combinational helpers only; no timing or flow control of their own.
package pmod_pkg;

    localparam int PMOD_ROWS         = 4;
    localparam int PMOD_COLS         = 4;
    localparam int PMOD_KEYS         = PMOD_ROWS * PMOD_COLS;
    localparam int KEY_W             = 4;
    localparam int KEY_CNT_W         = $clog2(PMOD_KEYS + 1);
    localparam int PMOD_DEFAULT_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        MULTI
    } key_state_e;

    function automatic logic [KEY_CNT_W-1:0] key_count(input logic [PMOD_KEYS-1:0] img);
        logic [KEY_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PMOD_KEYS; i++) begin
            cnt = cnt + KEY_CNT_W'(img[i]);
        end
        return cnt;
    endfunction

    // Lowest set bit; only meaningful when exactly one key is down.
    function automatic logic [KEY_W-1:0] key_index(input logic [PMOD_KEYS-1:0] img);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = PMOD_KEYS - 1; i >= 0; i--) begin
            if (img[i]) begin
                idx = KEY_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pmod_sync2.sv
// Two-flop synchroniser for asynchronous active-low inputs; 2-cycle latency, no backpressure.
// Resets to all-ones so a released (pulled-up) line reads inactive.
module pmod_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pmod_keypad_scan.sv
// 4x4 keypad scanner: column drive, sweep-image debounce, single-key press FSM.
// key_valid lands 2 cycles after the accepting sweep ends; no backpressure, strobe is fire-and-forget.
module pmod_keypad_scan
    import pmod_pkg::*;
#(
    parameter int frequency       = PMOD_DEFAULT_FREQ,
    parameter int scan_us         = 250,
    parameter int debounce_sweeps = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PMOD_COLS-1:0] col_n,
    input  logic [PMOD_ROWS-1:0] row_n,
    output logic [KEY_W-1:0]     key_code,
    output logic                 key_valid,
    output logic                 key_held
);

    localparam int COL_TICKS = frequency / 1_000_000 * scan_us;
    localparam int TW        = $clog2(COL_TICKS);
    localparam int MW        = $clog2(debounce_sweeps);
    localparam int CW        = $clog2(PMOD_COLS);

    localparam logic [TW-1:0] TICK_LAST = TW'(COL_TICKS - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(debounce_sweeps - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(PMOD_COLS - 1);

    logic [PMOD_ROWS-1:0] row_sync;

    logic [TW-1:0]        tick_q, tick_d;
    logic [CW-1:0]        col_q, col_d;
    logic [PMOD_KEYS-1:0] img_q, img_d, img_full;
    logic [PMOD_KEYS-1:0] prev_q, prev_d;
    logic [PMOD_KEYS-1:0] stable_q, stable_d;
    logic [MW-1:0]        match_q, match_d;
    logic                 chg_q, chg_d;
    key_state_e           state_q, state_d;
    logic [KEY_W-1:0]     key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_held_q, key_held_d;
    logic [KEY_CNT_W-1:0] n_keys;

    pmod_sync2 #(.WIDTH(PMOD_ROWS)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_sync)
    );

    // Image with the current column's row samples merged in.
    always_comb begin
        img_full = img_q;
        for (int r = 0; r < PMOD_ROWS; r++) begin
            img_full[r * PMOD_COLS + int'(col_q)] = ~row_sync[r];
        end
    end

    always_comb begin
        tick_d   = tick_q + TW'(1);
        col_d    = col_q;
        img_d    = img_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        match_d  = match_q;
        chg_d    = 1'b0;
        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            col_d  = col_q + CW'(1);
            img_d  = img_full;
            if (col_q == COL_LAST) begin
                if (img_full == prev_q) begin
                    match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
                end else begin
                    match_d = '0;
                end
                prev_d = img_full;
                if (match_d == MATCH_MAX && img_full != stable_q) begin
                    stable_d = img_full;
                    chg_d    = 1'b1;
                end
            end
        end
    end

    assign n_keys = key_count(stable_q);

    // A press is only reported when the accepted image moves from empty to exactly one key.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (chg_q) begin
            case (state_q)
                IDLE: begin
                    if (n_keys == KEY_CNT_W'(1)) begin
                        state_d     = PRESSED;
                        key_code_d  = key_index(stable_q);
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else if (n_keys != '0) begin
                        state_d = MULTI;
                    end
                end
                PRESSED: begin
                    key_held_d = 1'b0;
                    state_d    = (n_keys == '0) ? IDLE : MULTI;
                end
                MULTI: begin
                    if (n_keys == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q      <= '0;
            col_q       <= '0;
            img_q       <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            match_q     <= '0;
            chg_q       <= 1'b0;
            state_q     <= IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            col_q       <= col_d;
            img_q       <= img_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            match_q     <= match_d;
            chg_q       <= chg_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = ~(PMOD_COLS'(1) << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_pmod_keypad_scan.sv
// Directed bench for pmod_keypad_scan: 8 cycles/column, 32 cycles/sweep, 3-sweep debounce.
// A key pressed at the start of a sweep is reported 97 cycles later (3 sweeps + 1).
module tb_pmod_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;

    pmod_keypad_scan #(
        .frequency       (1_000_000),
        .scan_us         (8),
        .debounce_sweeps (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && !col_n[c]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    // Returns at the negedge just after col_n wrapped from column 3 to column 0.
    task automatic align_sweep();
        logic [3:0] prev;
        bit         found;
        prev  = col_n;
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (col_n == 4'b1110 && prev == 4'b0111) found = 1;
            prev = col_n;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL align_sweep: col_n=%b never wrapped to 1110 within 80 cycles", col_n);
        end
    endtask

    // Observes n negedges: strobe count, first strobe cycle, code at strobe, first cycle held is low.
    task automatic watch(input int n, output int nstr, output int first_k,
                         output logic [3:0] code_at, output int fall_k);
        nstr    = 0;
        first_k = -1;
        code_at = 4'hx;
        fall_k  = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                nstr++;
                if (first_k < 0) begin
                    first_k = k;
                    code_at = key_code;
                end
            end
            if (key_held === 1'b0 && fall_k < 0) fall_k = k;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b want 1110", col_n); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d want 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b want 0", key_held); end
        rst_n = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 8) % 4));
            checks++;
            if (col_n !== exp_col) begin
                errors++;
                $display("FAIL idle_col_n cycle %0d: got %b want %b", k, col_n, exp_col);
            end
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_strobe cycle %0d: key_valid=%b want 0", k, key_valid);
            end
        end
    endtask

    task automatic test_press_release();
        int nstr, first_k, fall_k;
        logic [3:0] code;
        align_sweep();
        pressed[9] = 1'b1;
        watch(160, nstr, first_k, code, fall_k);
        checks++; if (first_k != 97) begin errors++; $display("FAIL press_latency: strobe at %0d want 97", first_k); end
        checks++; if (nstr != 1) begin errors++; $display("FAIL press_count: %0d strobes want 1", nstr); end
        checks++; if (code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d want 9", code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held); end
        align_sweep();
        pressed[9] = 1'b0;
        watch(130, nstr, first_k, code, fall_k);
        checks++; if (fall_k != 97) begin errors++; $display("FAIL release_held_fall: at %0d want 97", fall_k); end
        checks++; if (nstr != 0) begin errors++; $display("FAIL release_strobe: %0d strobes want 0", nstr); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL release_code_kept: got %0d want 9", key_code); end
    endtask

    task automatic test_bounce();
        int nstr, first_k;
        logic [3:0] code;
        nstr    = 0;
        first_k = -1;
        code    = 4'hx;
        align_sweep();
        pressed[3] = 1'b1;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                nstr++;
                if (first_k < 0) begin
                    first_k = k;
                    code    = key_code;
                end
            end
            if (k < 160 && k % 20 == 0) pressed[3] = ~pressed[3];
            else if (k == 160) pressed[3] = 1'b1;
        end
        checks++; if (first_k != 257) begin errors++; $display("FAIL bounce_latency: strobe at %0d want 257", first_k); end
        checks++; if (nstr != 1) begin errors++; $display("FAIL bounce_count: %0d strobes want 1", nstr); end
        checks++; if (code !== 4'd3) begin errors++; $display("FAIL bounce_code: got %0d want 3", code); end
        pressed = '0;
        watch(140, nstr, first_k, code, first_k);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_release_held: got %b want 0", key_held); end
    endtask

    task automatic test_multi();
        int nstr, first_k, fall_k;
        logic [3:0] code;
        pressed[4] = 1'b1;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 1 || code !== 4'd4) begin errors++; $display("FAIL multi_first: %0d strobes code %0d want 1 code 4", nstr, code); end
        pressed[14] = 1'b1;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 0) begin errors++; $display("FAIL multi_add_strobe: %0d strobes want 0", nstr); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_add_held: got %b want 0", key_held); end
        checks++; if (key_code !== 4'd4) begin errors++; $display("FAIL multi_code_kept: got %0d want 4", key_code); end
        pressed = '0;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 0) begin errors++; $display("FAIL multi_release_strobe: %0d strobes want 0", nstr); end
        pressed[15] = 1'b1;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 1 || code !== 4'd15) begin errors++; $display("FAIL multi_next_press: %0d strobes code %0d want 1 code 15", nstr, code); end
        pressed = '0;
        watch(140, nstr, first_k, code, fall_k);
    endtask

    task automatic test_ghost();
        int nstr, first_k, fall_k;
        logic [3:0] code;
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 0) begin errors++; $display("FAIL ghost_pair_strobe: %0d strobes want 0", nstr); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_pair_held: got %b want 0", key_held); end
        pressed[5] = 1'b0;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 0) begin errors++; $display("FAIL ghost_single_left: %0d strobes want 0", nstr); end
        pressed = '0;
        watch(140, nstr, first_k, code, fall_k);
        pressed[5] = 1'b1;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 1 || code !== 4'd5) begin errors++; $display("FAIL ghost_fresh_press: %0d strobes code %0d want 1 code 5", nstr, code); end
    endtask

    task automatic test_reset_mid();
        int nstr, first_k, fall_k;
        logic [3:0] code;
        pressed = '0;
        watch(140, nstr, first_k, code, fall_k);
        pressed[6] = 1'b1;
        watch(140, nstr, first_k, code, fall_k);
        checks++; if (nstr != 1 || code !== 4'd6) begin errors++; $display("FAIL rst_pre_press: %0d strobes code %0d want 1 code 6", nstr, code); end
        align_sweep();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL rst_mid_col_n: got %b want 1110", col_n); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_mid_held: got %b want 0", key_held); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL rst_mid_code: got %0d want 0", key_code); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch(160, nstr, first_k, code, fall_k);
        checks++; if (first_k != 97) begin errors++; $display("FAIL rst_restrobe_latency: strobe at %0d want 97", first_k); end
        checks++; if (nstr != 1 || code !== 4'd6) begin errors++; $display("FAIL rst_restrobe: %0d strobes code %0d want 1 code 6", nstr, code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rst_restrobe_held: got %b want 1", key_held); end
    endtask

    initial begin
        rst_n   = 1'b0;
        pressed = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_multi();
        test_ghost();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
